bytewrite_ram_master: RTL

//  Request-side controller for one port of the byte-write no-change RAM (bytewrite_tdp_ram_nc).
//  - Accepts byte/half/word load and store requests at byte addresses over a valid/ready handshake.
//  - Drives the RAM enable, column write-enable, address and data lines.
//  - Splits accesses that cross a word boundary into two RAM cycles.
//  - Aligns read data and returns one response per request.

---
 rtl/bytewrite_ram_master_if.sv | 39 +++
 rtl/bytewrite_ram_master.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bytewrite_ram_master_if.sv
// Request/response bundle between a requester and bytewrite_ram_master.
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_size             0 byte, 1 half, 2 word, 3 illegal
//   req_addr             byte address
//   req_wdata            store data, LSB-aligned
//   rsp_valid/rsp_ready  response handshake
//   rsp_err              illegal size, no RAM access was made
//   rsp_rdata            load data, LSB-aligned, zero-extended
// master: requester side; slave: controller side.
interface bytewrite_ram_master_if #(
   parameter int NUM_COL    = 4,
   parameter int COL_WIDTH  = 8,
   parameter int ADDR_WIDTH = 6
);
   localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;
   localparam int OFS_W      = $clog2(NUM_COL);

   logic                        req_valid;
   logic                        req_ready;
   logic                        req_we;
   logic [1:0]                  req_size;
   logic [ADDR_WIDTH+OFS_W-1:0] req_addr;
   logic [DATA_WIDTH-1:0]       req_wdata;
   logic                        rsp_valid;
   logic                        rsp_ready;
   logic                        rsp_err;
   logic [DATA_WIDTH-1:0]       rsp_rdata;

   modport master (
      output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_err, rsp_rdata
   );
endinterface

// File: rtl/bytewrite_ram_master.sv
// Request-side controller for one port of a byte-write no-change RAM.
// Takes byte/half/word loads and stores at byte addresses, splits accesses
// that straddle a word boundary into two RAM cycles, and returns one aligned
// response per request.
//   clkA    clock, posedge
//   rstA_n  synchronous active-low reset
//   bus     request/response bundle (slave side)
//   enaA    RAM enable (registered)
//   weA     RAM column write enables (registered)
//   addrA   RAM word address (registered)
//   dinA    RAM write data (registered)
//   doutA   RAM read data, valid the cycle after a read enable
//
// state  | meaning
// IDLE   | ready for a request
// ISSUE0 | first (or only) RAM word being accessed
// ISSUE1 | second RAM word of a split access; word0 read data captured
// CAPT   | load only: capture the last read word
// RESP   | response held until rsp_ready
module bytewrite_ram_master #(
   parameter int NUM_COL    = 4,
   parameter int COL_WIDTH  = 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                           clkA,
   input  logic                           rstA_n,
   bytewrite_ram_master_if.slave          bus,
   output logic                           enaA,
   output logic [NUM_COL-1:0]             weA,
   output logic [ADDR_WIDTH-1:0]          addrA,
   output logic [NUM_COL*COL_WIDTH-1:0]   dinA,
   input  logic [NUM_COL*COL_WIDTH-1:0]   doutA
);
   localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;
   localparam int OFS_W      = $clog2(NUM_COL);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE0 = 3'd1,
      ISSUE1 = 3'd2,
      CAPT   = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic                    ena_nxt;
   logic [NUM_COL-1:0]      we_nxt;
   logic [ADDR_WIDTH-1:0]   addr_nxt;
   logic [DATA_WIDTH-1:0]   din_nxt;

   // request decode, valid while in IDLE
   logic [OFS_W-1:0]        req_ofs;
   logic [ADDR_WIDTH-1:0]   req_word;
   int                      req_n;
   logic                    req_illegal;
   logic [2*NUM_COL-1:0]    req_mask;
   logic                    accept;

   // latched request
   logic                    we_q;
   logic [1:0]              size_q;
   logic [OFS_W-1:0]        ofs_q;
   logic [ADDR_WIDTH-1:0]   word_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [NUM_COL-1:0]      hi_q;
   logic                    split_q;
   logic                    err_q;
   logic [DATA_WIDTH-1:0]   rd0;
   logic [DATA_WIDTH-1:0]   rd1;

   logic [2*DATA_WIDTH-1:0] rd_pair;
   logic [DATA_WIDTH-1:0]   rd_aligned;

   assign req_ofs  = bus.req_addr[OFS_W-1:0];
   assign req_word = bus.req_addr[ADDR_WIDTH+OFS_W-1:OFS_W];

   always_comb begin
      req_n       = 1 << bus.req_size;
      req_illegal = (bus.req_size == 2'd3) || (req_n > NUM_COL);
      req_mask    = '0;
      // columns o .. o+n-1 across two adjacent words
      for (int i = 0; i < 2*NUM_COL; i++) begin
         req_mask[i] = (i >= int'(req_ofs)) && (i < int'(req_ofs) + req_n);
      end
   end

   assign bus.req_ready = rstA_n && (state == IDLE);
   assign accept        = bus.req_valid && bus.req_ready;

   always_comb begin
      state_nxt = state;
      ena_nxt   = 1'b0;
      we_nxt    = '0;
      addr_nxt  = addrA;
      din_nxt   = dinA;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (req_illegal) begin
                  state_nxt = RESP;
               end else begin
                  state_nxt = ISSUE0;
                  ena_nxt   = 1'b1;
                  addr_nxt  = req_word;
                  we_nxt    = bus.req_we ? req_mask[NUM_COL-1:0] : '0;
                  din_nxt   = bus.req_wdata << (int'(req_ofs) * COL_WIDTH);
               end
            end
         end
         ISSUE0: begin
            if (split_q) begin
               state_nxt = ISSUE1;
               ena_nxt   = 1'b1;
               addr_nxt  = word_q + ADDR_WIDTH'(1);
               we_nxt    = we_q ? hi_q : '0;
               din_nxt   = wdata_q >> ((NUM_COL - int'(ofs_q)) * COL_WIDTH);
            end else begin
               state_nxt = we_q ? RESP : CAPT;
            end
         end
         ISSUE1: state_nxt = we_q ? RESP : CAPT;
         CAPT:   state_nxt = RESP;
         RESP: begin
            if (bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clkA) begin
      if (!rstA_n) begin
         state   <= IDLE;
         enaA    <= 1'b0;
         weA     <= '0;
         addrA   <= '0;
         dinA    <= '0;
         we_q    <= 1'b0;
         size_q  <= '0;
         ofs_q   <= '0;
         word_q  <= '0;
         wdata_q <= '0;
         hi_q    <= '0;
         split_q <= 1'b0;
         err_q   <= 1'b0;
         rd0     <= '0;
         rd1     <= '0;
      end else begin
         state <= state_nxt;
         enaA  <= ena_nxt;
         weA   <= we_nxt;
         addrA <= addr_nxt;
         dinA  <= din_nxt;
         if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            ofs_q   <= req_ofs;
            word_q  <= req_word;
            wdata_q <= bus.req_wdata;
            hi_q    <= req_mask[2*NUM_COL-1:NUM_COL];
            split_q <= (req_mask[2*NUM_COL-1:NUM_COL] != '0) && !req_illegal;
            err_q   <= req_illegal;
         end
         // word0 of a split load arrives while word1 is being issued
         if (state == ISSUE1 && !we_q) rd0 <= doutA;
         if (state == CAPT) begin
            if (split_q) rd1 <= doutA;
            else         rd0 <= doutA;
         end
      end
   end

   always_comb begin
      rd_pair    = {rd1, rd0} >> (int'(ofs_q) * COL_WIDTH);
      rd_aligned = rd_pair[DATA_WIDTH-1:0];
      for (int b = 0; b < NUM_COL; b++) begin
         if (b >= (1 << size_q)) rd_aligned[b*COL_WIDTH +: COL_WIDTH] = '0;
      end
   end

   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_err   = (state == RESP) && err_q;
   assign bus.rsp_rdata = ((state == RESP) && !we_q && !err_q) ? rd_aligned : '0;
endmodule
